// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle control for the combinational multiplier (MUL/MLA/xMULL/xMLAL).
// Define MUL_FLAGS_EN to enable N/Z flag generation; otherwise the flag outputs are tied 0.
module mul_sequencer #(
  parameter int MUL_LAT = 0,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             long_op,
  input  logic             acc,
  input  logic             sgn,
  input  logic             s_bit,
  input  logic [31:0]      rm_val,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      acc_lo,
  input  logic [31:0]      acc_hi,
  input  logic [IDX_W-1:0] rd_lo_idx,
  input  logic [IDX_W-1:0] rd_hi_idx,
  output logic [31:0]      mul_b,
  output logic [31:0]      mul_c,
  output logic             mul_ld,
  output logic             mul_hilo,
  output logic             mul_u,
  input  logic [31:0]      mul_prod,
  output logic             wb_valid,
  output logic [IDX_W-1:0] wb_idx,
  output logic [31:0]      wb_data,
  input  logic             wb_ready,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_valid,
  output logic             busy
);
  localparam logic [2:0] IDLE = 3'd0, LO = 3'd1, HI = 3'd2, ADD = 3'd3, WB_LO = 3'd4, WB_HI = 3'd5;
  localparam int CW = MUL_LAT > 0 ? $clog2(MUL_LAT + 1) : 1;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic long_r, sgn_r, s_r;
  logic [IDX_W-1:0] rd_lo_r, rd_hi_r;
  logic [63:0] acc_v, prod, res;
  logic last;
  assign mul_ld = state == LO || state == HI;
  assign mul_hilo = state == HI;
  assign mul_u = mul_ld & sgn_r & long_r;
  assign wb_valid = state == WB_LO || state == WB_HI;
  assign wb_idx = state == WB_HI ? rd_hi_r : wb_valid ? rd_lo_r : '0;
  assign wb_data = state == WB_HI ? res[63:32] : wb_valid ? res[31:0] : '0;
  assign busy = state != IDLE;
  assign last = wb_valid & wb_ready & (state == WB_HI || !long_r);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      long_r <= 1'b0;
      sgn_r <= 1'b0;
      s_r <= 1'b0;
      rd_lo_r <= '0;
      rd_hi_r <= '0;
      acc_v <= '0;
      prod <= '0;
      res <= '0;
      mul_b <= '0;
      mul_c <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          long_r <= long_op;
          sgn_r <= sgn;
          s_r <= s_bit;
          rd_lo_r <= rd_lo_idx;
          rd_hi_r <= rd_hi_idx;
          // accumulate operand pre-shaped so ADD is a single 64-bit sum
          acc_v <= acc ? {long_op ? acc_hi : 32'd0, acc_lo} : 64'd0;
          mul_b <= rm_val;
          mul_c <= rs_val;
          cnt <= CW'(MUL_LAT);
          state <= LO;
        end
        LO: if (cnt == '0) begin
          prod[31:0] <= mul_prod;
          cnt <= CW'(MUL_LAT);
          state <= long_r ? HI : ADD;
        end else cnt <= cnt - CW'(1);
        HI: if (cnt == '0) begin
          prod[63:32] <= mul_prod;
          state <= ADD;
        end else cnt <= cnt - CW'(1);
        ADD: begin
          res <= {long_r ? prod[63:32] : 32'd0, prod[31:0]} + acc_v;
          state <= WB_LO;
        end
        WB_LO: if (wb_ready) state <= long_r ? WB_HI : IDLE;
        WB_HI: if (wb_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MUL_FLAGS_EN
  assign flag_valid = last & s_r;
  assign flag_n = flag_valid & (long_r ? res[63] : res[31]);
  assign flag_z = flag_valid & (long_r ? res == 64'd0 : res[31:0] == 32'd0);
`else
  logic unused;
  assign unused = s_r ^ last;
  assign flag_valid = 1'b0;
  assign flag_n = 1'b0;
  assign flag_z = 1'b0;
`endif
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed bench with a behavioural multiplier and a result-queue model.
// Build with MUL_FLAGS_EN defined to also check flag generation.
module tb_mul_sequencer;
`ifdef MUL_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 0, rst_n = 0, start = 0, long_op = 0, acc = 0, sgn = 0, s_bit = 0, wb_ready = 1;
  logic [31:0] rm_val = 0, rs_val = 0, acc_lo = 0, acc_hi = 0;
  logic [3:0] rd_lo_idx = 0, rd_hi_idx = 0;
  logic [31:0] mul_b, mul_c, mul_prod, wb_data;
  logic [3:0] wb_idx;
  logic mul_ld, mul_hilo, mul_u, wb_valid, flag_n, flag_z, flag_valid, busy;
  logic [63:0] p;
  int checks = 0, failures = 0, pulses = 0;
  logic last_n = 0, last_z = 0;
  typedef struct {logic [3:0] idx; logic [31:0] data; logic last; logic s; logic n; logic z;} wb_t;
  wb_t q[$];
  logic [31:0] got[$];
  logic [3:0] got_idx[$];
  logic [31:0] m_rm = 0, m_rs = 0;
  logic m_u = 0;

  mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .long_op(long_op), .acc(acc), .sgn(sgn),
    .s_bit(s_bit), .rm_val(rm_val), .rs_val(rs_val), .acc_lo(acc_lo), .acc_hi(acc_hi),
    .rd_lo_idx(rd_lo_idx), .rd_hi_idx(rd_hi_idx), .mul_b(mul_b), .mul_c(mul_c),
    .mul_ld(mul_ld), .mul_hilo(mul_hilo), .mul_u(mul_u), .mul_prod(mul_prod),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data), .wb_ready(wb_ready),
    .flag_n(flag_n), .flag_z(flag_z), .flag_valid(flag_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural multiplier: U=1 signed, HiLo picks the product word
  assign p = {{32{mul_u & mul_b[31]}}, mul_b} * {{32{mul_u & mul_c[31]}}, mul_c};
  assign mul_prod = mul_hilo ? p[63:32] : p[31:0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : model
    logic [63:0] pr, r;
    logic [31:0] r32;
    logic fe;
    if (!rst_n) q.delete();
    else begin
      if (mul_ld) begin
        chk("mul_b", mul_b, m_rm);
        chk("mul_c", mul_c, m_rs);
        chk("mul_u", mul_u, m_u);
      end
      fe = FE && wb_valid && wb_ready && q.size() > 0 && q[0].last && q[0].s;
      chk("flag_valid", flag_valid, fe);
      if (flag_valid) begin
        pulses++;
        last_n = flag_n;
        last_z = flag_z;
      end
      if (wb_valid) begin
        if (q.size() == 0) chk("wb_unexpected", wb_valid, 0);
        else begin
          chk("wb_idx", wb_idx, q[0].idx);
          chk("wb_data", wb_data, q[0].data);
          if (fe) begin
            chk("flag_n", flag_n, q[0].n);
            chk("flag_z", flag_z, q[0].z);
          end
          if (wb_ready) begin
            got.push_back(wb_data);
            got_idx.push_back(wb_idx);
            void'(q.pop_front());
          end
        end
      end
      if (start && !busy) begin
        m_rm = rm_val;
        m_rs = rs_val;
        m_u = sgn & long_op;
        pr = (sgn && long_op) ? 64'(longint'($signed(rm_val)) * longint'($signed(rs_val)))
                              : 64'(rm_val) * 64'(rs_val);
        if (long_op) begin
          r = pr + (acc ? {acc_hi, acc_lo} : 64'd0);
          q.push_back('{rd_lo_idx, r[31:0], 1'b0, s_bit, 1'b0, 1'b0});
          q.push_back('{rd_hi_idx, r[63:32], 1'b1, s_bit, r[63], r == 64'd0});
        end else begin
          r32 = pr[31:0] + (acc ? acc_lo : 32'd0);
          q.push_back('{rd_lo_idx, r32, 1'b1, s_bit, r32[31], r32 == 32'd0});
        end
      end
    end
  end

  task automatic setup(input logic l, a, sg, s, input logic [31:0] rm, rs, al, ah, input logic [3:0] ri, rh);
    long_op = l; acc = a; sgn = sg; s_bit = s;
    rm_val = rm; rs_val = rs; acc_lo = al; acc_hi = ah;
    rd_lo_idx = ri; rd_hi_idx = rh;
  endtask

  task automatic run(input logic l, a, sg, s, input logic [31:0] rm, rs, al, ah,
                     input logic [3:0] ri, rh, output int n);
    @(posedge clk); #1;
    got.delete(); got_idx.delete();
    setup(l, a, sg, s, rm, rs, al, ah, ri, rh);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 1;
    while (busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, k, p0;
    logic [31:0] d0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, mul_ld, mul_hilo, mul_u, wb_valid, flag_n, flag_z, flag_valid}, 0);
    chk("reset_mul_bc", {mul_b, mul_c}, 0);
    chk("reset_wb", {wb_idx, wb_data}, 0);
    rst_n = 1;

    run(0, 1, 0, 0, 5, 5, 7, 0, 3, 0, n);
    chk("mla_latency", n, 4);
    chk("mla_count", got.size(), 1);
    chk("mla_data", got[0], 32);
    chk("mla_idx", got_idx[0], 3);

    run(1, 0, 0, 0, 4000000, 4000000, 0, 0, 1, 2, n);
    chk("umull_latency", n, 6);
    chk("umull_count", got.size(), 2);
    chk("umull_lo", got[0], 32'h4A510000);
    chk("umull_hi", got[1], 32'h00000E8D);

    run(1, 0, 1, 1, 32'hFFC2F700, 4000000, 0, 0, 1, 2, n);
    chk("smull_lo", got[0], 32'hB5AF0000);
    chk("smull_hi", got[1], 32'hFFFFF172);

    run(1, 1, 0, 0, 32'hFFFFFFFF, 1, 1, 0, 6, 7, n);
    chk("umlal_lo", got[0], 32'h00000000);
    chk("umlal_hi", got[1], 32'h00000001);
    chk("umlal_idx", {got_idx[0], got_idx[1]}, 8'h67);

    run(1, 0, 0, 0, 2, 3, 0, 0, 5, 5, n);
    chk("same_idx_order", {got_idx[0], got[0], got_idx[1], got[1]}, {4'd5, 32'd6, 4'd5, 32'd0});

    p0 = pulses;
    run(0, 0, 0, 1, 0, 7, 0, 0, 4, 0, n);
    chk("mul0_data", got[0], 0);
`ifdef MUL_FLAGS_EN
    chk("mul0_pulses", pulses - p0, 1);
    chk("mul0_z", last_z, 1);
    chk("mul0_n", last_n, 0);
`else
    chk("mul0_no_flags", pulses - p0, 0);
`endif

    // writeback stall with an ignored second START
    @(posedge clk); #1;
    got.delete(); got_idx.delete();
    setup(1, 0, 0, 0, 4000000, 4000000, 0, 0, 1, 2);
    wb_ready = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    k = 0;
    while (!wb_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("stall_reach_wb", wb_valid, 1);
    d0 = wb_data;
    setup(0, 0, 0, 0, 9, 9, 0, 0, 9, 9);
    start = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 0;
      chk("stall_valid", wb_valid, 1);
      chk("stall_data", wb_data, d0);
      chk("stall_busy", busy, 1);
    end
    chk("stall_mul_b", mul_b, 4000000);
    wb_ready = 1;
    k = 0;
    while (busy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("stall_done", busy, 0);
    chk("stall_words", {got[0], got[1]}, {32'h4A510000, 32'h00000E8D});
    chk("stall_count", got.size(), 2);

    // asynchronous reset while collecting the Hi word
    @(posedge clk); #1;
    setup(1, 1, 1, 1, 32'h12345678, 32'h9ABCDEF0, 1, 2, 3, 4);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    k = 0;
    while (!mul_hilo && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_reach_hi", mul_hilo, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_ctrl", {busy, mul_ld, mul_hilo, mul_u, wb_valid, flag_n, flag_z, flag_valid}, 0);
    chk("rst_mul_bc", {mul_b, mul_c}, 0);
    chk("rst_wb", {wb_idx, wb_data}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rst_no_wb", {wb_valid, busy}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
